// File: rtl/sine_cfg_sched_pkg.sv
// Shared constants, FSM encoding and wrap-aware step helpers for the
// DDS configuration scheduler.
package sine_cfg_sched_pkg;

  localparam logic [4:0] FREQ_MIN = 5'd1;
  localparam logic [4:0] FREQ_MAX = 5'd30;
  localparam logic [4:0] AMP_MIN  = 5'd10;
  localparam logic [4:0] AMP_MAX  = 5'd20;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROM_RD = 2'd1,
    LOAD   = 2'd2,
    DWELL  = 2'd3
  } state_t;

  // Frequency index +1 with wrap FREQ_MAX -> FREQ_MIN
  function automatic logic [4:0] freq_up(input logic [4:0] f);
    return (f >= FREQ_MAX) ? FREQ_MIN : f + 5'd1;
  endfunction

  // Frequency index -1 with wrap FREQ_MIN -> FREQ_MAX
  function automatic logic [4:0] freq_dn(input logic [4:0] f);
    return (f <= FREQ_MIN) ? FREQ_MAX : f - 5'd1;
  endfunction

  // Amplitude code +1 with wrap AMP_MAX -> AMP_MIN
  function automatic logic [4:0] amp_up(input logic [4:0] a);
    return (a >= AMP_MAX) ? AMP_MIN : a + 5'd1;
  endfunction

endpackage

// File: rtl/sine_cfg_sched_dwell_timer.sv
// Sweep dwell counter: counts 0..DWELL_CYC-1 while enabled and emits a
// one-cycle terminal-count pulse on the last count.
module sine_cfg_sched_dwell_timer
  import sine_cfg_sched_pkg::*;
#(
  parameter int DWELL_CYC = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL_CYC - 1);

  logic [CW-1:0] cnt;

  assign tc = en && (cnt == LAST);

  // Count while enabled; restart on clear or after the terminal count
  always_ff @(posedge clk) begin
    if (!rst_n || clr || tc) cnt <= '0;
    else if (en)             cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/sine_cfg_sched.sv
// Configuration scheduler for the DDS sine path: turns key pulses into a
// (frequency, amplitude, gain) set, fetches the gain from the calibration
// ROM and offers the set to the DDS over valid/ready. Also runs the
// auto-sweep across all frequency indices.
module sine_cfg_sched
  import sine_cfg_sched_pkg::*;
#(
  parameter int ROM_LAT   = 2,
  parameter int DWELL_CYC = 50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_up,
  input  logic        key_dn,
  input  logic        key_amp,
  input  logic        key_mode,
  output logic [4:0]  rom_addr,
  input  logic [10:0] rom_data,
  output logic [4:0]  cfg_freq,
  output logic [4:0]  cfg_amp,
  output logic [10:0] cfg_gain,
  output logic        cfg_valid,
  input  logic        cfg_ready,
  output logic [4:0]  disp_freq,
  output logic [4:0]  disp_amp,
  output logic        sweep_on,
  output logic        busy
);

  localparam int RCW = (ROM_LAT > 0) ? $clog2(ROM_LAT + 1) : 1;
  localparam logic [RCW-1:0] RD_LAST = RCW'(ROM_LAT);

  state_t         state, state_nxt;
  logic [RCW-1:0] rd_cnt;
  logic           boot, boot_nxt;
  logic           pend_mode, pend_up, pend_dn, pend_amp;
  logic           pm_nxt, pu_nxt, pd_nxt, pa_nxt;
  logic           e_mode, e_up, e_dn, e_amp, freq_chg;
  logic [4:0]     freq_nxt, amp_nxt;
  logic           sweep_nxt, rd_start, xfer, rd_done, dwell_tc;

  // A key counts if it is live this cycle or was latched while busy
  assign e_mode   = key_mode | pend_mode;
  assign e_up     = key_up   | pend_up;
  assign e_dn     = key_dn   | pend_dn;
  assign e_amp    = key_amp  | pend_amp;
  assign freq_chg = !sweep_on && (e_up ^ e_dn);
  assign rd_done  = (state == ROM_RD) && (rd_cnt == RD_LAST);

  assign cfg_valid = (state == LOAD);
  assign busy      = (state == ROM_RD) || (state == LOAD);

  sine_cfg_sched_dwell_timer #(.DWELL_CYC(DWELL_CYC)) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state != DWELL),
    .en    (state == DWELL),
    .tc    (dwell_tc)
  );

  // Next-state, key servicing and pending-flag bookkeeping
  always_comb begin
    state_nxt = state;
    boot_nxt  = boot;
    freq_nxt  = cfg_freq;
    amp_nxt   = cfg_amp;
    sweep_nxt = sweep_on;
    pm_nxt    = e_mode;
    pu_nxt    = e_up;
    pd_nxt    = e_dn;
    pa_nxt    = e_amp;
    rd_start  = 1'b0;
    xfer      = 1'b0;
    case (state)
      IDLE, DWELL: begin
        if (boot) begin
          // Power-up configuration is always fetched and loaded
          boot_nxt  = 1'b0;
          state_nxt = ROM_RD;
          rd_start  = 1'b1;
        end else if (e_mode) begin
          pm_nxt    = 1'b0;
          sweep_nxt = !sweep_on;
          if (!sweep_on) begin
            // Entering sweep: restart at the lowest index, fold in any amp step
            pu_nxt   = 1'b0;
            pd_nxt   = 1'b0;
            freq_nxt = FREQ_MIN;
            if (e_amp) begin
              amp_nxt = amp_up(cfg_amp);
              pa_nxt  = 1'b0;
            end
            state_nxt = ROM_RD;
            rd_start  = 1'b1;
          end else begin
            // Leaving sweep keeps the index; other keys wait one cycle
            state_nxt = IDLE;
          end
        end else begin
          // Up+dn together, or up/dn in sweep, are simply dropped
          pu_nxt = 1'b0;
          pd_nxt = 1'b0;
          pa_nxt = 1'b0;
          if (freq_chg) freq_nxt = e_up ? freq_up(cfg_freq) : freq_dn(cfg_freq);
          if (e_amp)    amp_nxt  = amp_up(cfg_amp);
          if (freq_chg) begin
            state_nxt = ROM_RD;
            rd_start  = 1'b1;
          end else if (e_amp) begin
            state_nxt = LOAD;
          end else if (state == DWELL && dwell_tc) begin
            freq_nxt  = freq_up(cfg_freq);
            state_nxt = ROM_RD;
            rd_start  = 1'b1;
          end
        end
      end
      ROM_RD: begin
        if (rd_done) state_nxt = LOAD;
      end
      LOAD: begin
        if (cfg_ready) begin
          xfer      = 1'b1;
          state_nxt = sweep_on ? DWELL : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state and control flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      boot      <= 1'b1;
      sweep_on  <= 1'b0;
      pend_mode <= 1'b0;
      pend_up   <= 1'b0;
      pend_dn   <= 1'b0;
      pend_amp  <= 1'b0;
      rd_cnt    <= '0;
    end else begin
      state     <= state_nxt;
      boot      <= boot_nxt;
      sweep_on  <= sweep_nxt;
      pend_mode <= pm_nxt;
      pend_up   <= pu_nxt;
      pend_dn   <= pd_nxt;
      pend_amp  <= pa_nxt;
      if (rd_start)              rd_cnt <= '0;
      else if (state == ROM_RD)  rd_cnt <= rd_cnt + 1'b1;
    end
  end

  // Pending config, ROM address/gain capture and display registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_freq  <= FREQ_MIN;
      cfg_amp   <= AMP_MIN;
      cfg_gain  <= '0;
      rom_addr  <= '0;
      disp_freq <= FREQ_MIN;
      disp_amp  <= AMP_MIN;
    end else begin
      cfg_freq <= freq_nxt;
      cfg_amp  <= amp_nxt;
      if (rd_start) rom_addr <= freq_nxt - 5'd1;
      if (rd_done)  cfg_gain <= rom_data;
      if (xfer) begin
        disp_freq <= cfg_freq;
        disp_amp  <= cfg_amp;
      end
    end
  end

endmodule

// File: tb/tb_sine_cfg_sched.sv
// Directed bench for sine_cfg_sched: table of manual key steps plus
// hand-written sequences for backpressure, sweep, mode exit and reset.
module tb_sine_cfg_sched;

  localparam int ROM_LAT   = 2;
  localparam int DWELL_CYC = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_up, key_dn, key_amp, key_mode;
  logic [4:0]  rom_addr;
  logic [10:0] rom_data;
  logic [10:0] rom_q1;
  logic [4:0]  cfg_freq, cfg_amp;
  logic [10:0] cfg_gain;
  logic        cfg_valid, cfg_ready;
  logic [4:0]  disp_freq, disp_amp;
  logic        sweep_on, busy;

  int checks = 0;
  int errors = 0;

  int xfer_cnt  = 0;
  int gap_run   = 0;
  int last_freq = 0;
  int last_amp  = 0;
  int last_gain = 0;
  int last_gap  = 0;

  typedef struct {
    logic       up, dn, amp;
    logic [4:0] f, a;
    logic [10:0] g;
    logic [4:0] addr;
  } vec_t;

  vec_t vecs[7];

  sine_cfg_sched #(.ROM_LAT(ROM_LAT), .DWELL_CYC(DWELL_CYC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_up    (key_up),
    .key_dn    (key_dn),
    .key_amp   (key_amp),
    .key_mode  (key_mode),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .cfg_freq  (cfg_freq),
    .cfg_amp   (cfg_amp),
    .cfg_gain  (cfg_gain),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .disp_freq (disp_freq),
    .disp_amp  (disp_amp),
    .sweep_on  (sweep_on),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Gain ROM model: data = 100 + addr, two cycles after the address
  always @(posedge clk) begin
    rom_q1   <= 11'(100 + int'(rom_addr));
    rom_data <= rom_q1;
  end

  // Transfer monitor: records each accepted set and the idle gap before it
  always @(posedge clk) begin
    if (rst_n && cfg_valid && cfg_ready) begin
      xfer_cnt++;
      last_freq = int'(cfg_freq);
      last_amp  = int'(cfg_amp);
      last_gain = int'(cfg_gain);
      last_gap  = gap_run;
      gap_run   = 0;
    end else if (rst_n && !busy) begin
      gap_run++;
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse(input logic up, input logic dn, input logic amp, input logic mode);
    key_up = up; key_dn = dn; key_amp = amp; key_mode = mode;
    tick();
    key_up = 1'b0; key_dn = 1'b0; key_amp = 1'b0; key_mode = 1'b0;
  endtask

  task automatic wait_xfer(input int budget, input bit poke_up, input string tag);
    int start;
    int n;
    start = xfer_cnt;
    n = 0;
    while (xfer_cnt == start && n < budget) begin
      key_up = poke_up && (n % 7 == 3);
      tick();
      n++;
    end
    key_up = 1'b0;
    checks++;
    if (xfer_cnt == start) begin
      errors++;
      $display("FAIL %s: no transfer within %0d cycles (got 0 expected 1)", tag, budget);
    end
  endtask

  initial begin
    int base;
    int ea;
    int ef;

    vecs[0] = '{up:1'b0, dn:1'b1, amp:1'b0, f:5'd30, a:5'd10, g:11'd129, addr:5'd29};
    vecs[1] = '{up:1'b1, dn:1'b0, amp:1'b0, f:5'd1,  a:5'd10, g:11'd100, addr:5'd0};
    vecs[2] = '{up:1'b1, dn:1'b0, amp:1'b0, f:5'd2,  a:5'd10, g:11'd101, addr:5'd1};
    vecs[3] = '{up:1'b0, dn:1'b0, amp:1'b1, f:5'd2,  a:5'd11, g:11'd101, addr:5'd1};
    vecs[4] = '{up:1'b1, dn:1'b0, amp:1'b1, f:5'd3,  a:5'd12, g:11'd102, addr:5'd2};
    vecs[5] = '{up:1'b0, dn:1'b1, amp:1'b1, f:5'd2,  a:5'd13, g:11'd101, addr:5'd1};
    vecs[6] = '{up:1'b0, dn:1'b1, amp:1'b0, f:5'd1,  a:5'd13, g:11'd100, addr:5'd0};

    rst_n = 1'b0; cfg_ready = 1'b1;
    key_up = 1'b0; key_dn = 1'b0; key_amp = 1'b0; key_mode = 1'b0;
    repeat (4) tick();

    // Reset values
    check("rst cfg_valid", int'(cfg_valid), 0);
    check("rst cfg_freq",  int'(cfg_freq), 1);
    check("rst cfg_amp",   int'(cfg_amp), 10);
    check("rst cfg_gain",  int'(cfg_gain), 0);
    check("rst rom_addr",  int'(rom_addr), 0);
    check("rst disp_freq", int'(disp_freq), 1);
    check("rst disp_amp",  int'(disp_amp), 10);
    check("rst sweep_on",  int'(sweep_on), 0);

    // Power-up load: valid on the fourth cycle after release
    rst_n = 1'b1;
    repeat (3) tick();
    check("boot valid c3", int'(cfg_valid), 0);
    check("boot busy c3",  int'(busy), 1);
    tick();
    check("boot valid c4", int'(cfg_valid), 1);
    check("boot freq",     int'(cfg_freq), 1);
    check("boot amp",      int'(cfg_amp), 10);
    check("boot gain",     int'(cfg_gain), 100);
    check("boot rom_addr", int'(rom_addr), 0);
    tick();
    check("boot disp_freq", int'(disp_freq), 1);
    check("boot busy idle", int'(busy), 0);
    check("boot valid low", int'(cfg_valid), 0);

    // Manual stepping table
    for (int i = 0; i < 7; i++) begin
      pulse(vecs[i].up, vecs[i].dn, vecs[i].amp, 1'b0);
      wait_xfer(40, 1'b0, "vec xfer");
      check($sformatf("vec%0d disp_freq", i), int'(disp_freq), int'(vecs[i].f));
      check($sformatf("vec%0d disp_amp", i),  int'(disp_amp),  int'(vecs[i].a));
      check($sformatf("vec%0d cfg_gain", i),  int'(cfg_gain),  int'(vecs[i].g));
      check($sformatf("vec%0d rom_addr", i),  int'(rom_addr),  int'(vecs[i].addr));
    end

    // Amplitude wraps 20 -> 10; eleven steps return to the start value
    ea = 13;
    for (int i = 0; i < 11; i++) begin
      ea = (ea == 20) ? 10 : ea + 1;
      pulse(1'b0, 1'b0, 1'b1, 1'b0);
      wait_xfer(20, 1'b0, "amp xfer");
      check($sformatf("amp step %0d", i), int'(disp_amp), ea);
    end
    check("amp x11 back", int'(disp_amp), 13);

    // Backpressure: keys during a stalled LOAD collapse to one follow-up load
    cfg_ready = 1'b0;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4) tick();
    check("stall valid", int'(cfg_valid), 1);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("stall cfg_freq", int'(cfg_freq), 2);
    check("stall cfg_amp",  int'(cfg_amp), 13);
    check("stall cfg_gain", int'(cfg_gain), 101);
    check("stall busy",     int'(busy), 1);
    check("stall valid2",   int'(cfg_valid), 1);
    check("stall disp",     int'(disp_freq), 1);
    cfg_ready = 1'b1;
    wait_xfer(10, 1'b0, "stall xfer1");
    check("stall x1 freq", last_freq, 2);
    check("stall x1 amp",  last_amp, 13);
    wait_xfer(20, 1'b0, "stall xfer2");
    check("stall x2 freq", last_freq, 3);
    check("stall x2 amp",  last_amp, 14);
    check("stall x2 gain", last_gain, 102);
    base = xfer_cnt;
    repeat (30) tick();
    check("stall no extra", xfer_cnt - base, 0);

    // Sweep: 1..30 then wrap, 20 idle cycles per step, key_up ignored
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("sweep on", int'(sweep_on), 1);
    for (int i = 0; i < 37; i++) begin
      ef = (i % 30) + 1;
      wait_xfer(60, 1'b1, "sweep xfer");
      check($sformatf("sweep%0d freq", i), last_freq, ef);
      check($sformatf("sweep%0d gain", i), last_gain, 99 + ef);
      check($sformatf("sweep%0d amp", i),  last_amp, 14);
      if (i > 0) check($sformatf("sweep%0d gap", i), last_gap, DWELL_CYC);
    end

    // Leave sweep mid-dwell at index 7
    repeat (10) tick();
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("exit sweep_on", int'(sweep_on), 0);
    check("exit busy",     int'(busy), 0);
    base = xfer_cnt;
    repeat (60) tick();
    check("exit no load",   xfer_cnt - base, 0);
    check("exit disp_freq", int'(disp_freq), 7);

    // up+dn in the same cycle is discarded
    base = xfer_cnt;
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (30) tick();
    check("updn live no load", xfer_cnt - base, 0);
    check("updn live freq",    int'(cfg_freq), 7);

    // up and dn both pending is also discarded
    cfg_ready = 1'b0;
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check("updn pend busy", int'(busy), 1);
    cfg_ready = 1'b1;
    wait_xfer(10, 1'b0, "updn pend xfer");
    check("updn pend amp",  last_amp, 15);
    check("updn pend freq", last_freq, 7);
    base = xfer_cnt;
    repeat (30) tick();
    check("updn pend no load", xfer_cnt - base, 0);
    check("updn pend disp",    int'(disp_freq), 7);

    // Reset while LOAD is holding cfg_valid
    cfg_ready = 1'b0;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4) tick();
    check("rl valid", int'(cfg_valid), 1);
    check("rl freq",  int'(cfg_freq), 8);
    base = xfer_cnt;
    rst_n = 1'b0;
    tick();
    check("rl2 valid",     int'(cfg_valid), 0);
    check("rl2 disp_freq", int'(disp_freq), 1);
    check("rl2 disp_amp",  int'(disp_amp), 10);
    check("rl2 cfg_freq",  int'(cfg_freq), 1);
    check("rl2 cfg_amp",   int'(cfg_amp), 10);
    check("rl2 cfg_gain",  int'(cfg_gain), 0);
    check("rl2 rom_addr",  int'(rom_addr), 0);
    check("rl2 busy",      int'(busy), 0);
    check("rl2 no xfer",   xfer_cnt - base, 0);
    rst_n = 1'b1;
    cfg_ready = 1'b1;
    wait_xfer(20, 1'b0, "reboot xfer");
    check("reboot freq", last_freq, 1);
    check("reboot amp",  last_amp, 10);
    check("reboot gain", last_gain, 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
